qp_delta: RTL and testbench



---
 rtl/qp_delta_pkg.sv | 20 ++
 rtl/egk_bin_gen.sv | 93 +++++++++
 rtl/qp_delta.sv | 134 +++++++++++++
 tb/tb_qp_delta.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/qp_delta_pkg.sv
// Shared types and constants for the cu_qp_delta_abs binarizer.
package qp_delta_pkg;

    localparam int QP_DELTA_CMAX = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFIX,
        ST_SUF_UNARY,
        ST_SUF_FIXED,
        ST_DONE
    } qp_state_e;

    typedef enum logic [1:0] {
        EG_IDLE,
        EG_UNARY,
        EG_FIXED
    } egk_phase_e;

endpackage

// File: rtl/egk_bin_gen.sv
// Serial Exp-Golomb-k bin generator: unary part, terminating 0, then k fixed bits MSB first.
module egk_bin_gen
    import qp_delta_pkg::*;
#(
    parameter int VALUE_WIDTH = 16,
    parameter int K           = 0,
    parameter int KW          = $clog2(VALUE_WIDTH + K + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [VALUE_WIDTH-1:0] i_value,
    output logic                   o_bin_valid,
    output logic                   o_bin,
    output logic                   o_last
);

    localparam logic [VALUE_WIDTH:0] POW_INIT = {{VALUE_WIDTH{1'b0}}, 1'b1} << K;

    egk_phase_e             r_phase;
    logic [VALUE_WIDTH-1:0] r_s;
    logic [KW-1:0]          r_k;
    logic [KW-1:0]          r_idx;
    logic [VALUE_WIDTH:0]   r_pow;

    logic                   w_ge;
    logic [VALUE_WIDTH-1:0] w_shifted;
    logic                   w_fixed_bit;

    // 2^k is held one bit wider than s so the compare never wraps
    assign w_ge        = ({1'b0, r_s} >= r_pow);
    assign w_shifted   = r_s >> r_idx;
    assign w_fixed_bit = w_shifted[0];

    always_comb begin
        o_bin_valid = 1'b0;
        o_bin       = 1'b0;
        o_last      = 1'b0;
        case (r_phase)
            EG_UNARY: begin
                o_bin_valid = 1'b1;
                o_bin       = w_ge;
                o_last      = !w_ge && (r_k == '0);
            end
            EG_FIXED: begin
                o_bin_valid = 1'b1;
                o_bin       = w_fixed_bit;
                o_last      = (r_idx == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase <= EG_IDLE;
            r_s     <= '0;
            r_k     <= '0;
            r_idx   <= '0;
            r_pow   <= '0;
        end else if (i_start) begin
            r_phase <= EG_UNARY;
            r_s     <= i_value;
            r_k     <= KW'(K);
            r_idx   <= '0;
            r_pow   <= POW_INIT;
        end else begin
            case (r_phase)
                EG_UNARY: begin
                    if (w_ge) begin
                        r_s   <= r_s - r_pow[VALUE_WIDTH-1:0];
                        r_k   <= r_k + 1'b1;
                        r_pow <= r_pow << 1;
                    end else if (r_k == '0) begin
                        r_phase <= EG_IDLE;
                    end else begin
                        r_phase <= EG_FIXED;
                        r_idx   <= r_k - 1'b1;
                    end
                end
                EG_FIXED: begin
                    if (r_idx == '0) begin
                        r_phase <= EG_IDLE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                default: r_phase <= EG_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/qp_delta.sv
// cu_qp_delta_abs binarizer: TU prefix (cMax 5) followed by an EGk suffix on (v - 5).
module qp_delta
    import qp_delta_pkg::*;
#(
    parameter int BIN_WIDTH   = 16,
    parameter int VALUE_WIDTH = 16,
    parameter int K           = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [VALUE_WIDTH-1:0] Cu_qp_delta_abs,
    output logic                   done,
    output logic [BIN_WIDTH-1:0]   bin_string,
    output logic [BIN_WIDTH-1:0]   bin_length
);

    localparam logic [VALUE_WIDTH-1:0] CMAX_V    = VALUE_WIDTH'(QP_DELTA_CMAX);
    localparam logic [2:0]             LAST_ONE  = 3'(QP_DELTA_CMAX - 1);

    qp_state_e              r_state;
    logic [VALUE_WIDTH-1:0] r_value;
    logic [2:0]             r_pcnt;
    logic                   r_done;
    logic [BIN_WIDTH-1:0]   r_bins;
    logic [BIN_WIDTH-1:0]   r_len;

    logic                   w_long;
    logic                   w_pbin;
    logic                   w_egk_start;
    logic [VALUE_WIDTH-1:0] w_suffix_val;
    logic                   w_egk_valid;
    logic                   w_egk_bin;
    logic                   w_egk_last;
    logic                   w_append;
    logic                   w_bin;

    assign w_long       = (r_value >= CMAX_V);
    assign w_pbin       = w_long || (VALUE_WIDTH'(r_pcnt) < r_value);
    assign w_egk_start  = (r_state == ST_PREFIX) && w_long && (r_pcnt == LAST_ONE);
    assign w_suffix_val = r_value - CMAX_V;

    egk_bin_gen #(
        .VALUE_WIDTH (VALUE_WIDTH),
        .K           (K)
    ) u_egk (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_egk_start),
        .i_value     (w_suffix_val),
        .o_bin_valid (w_egk_valid),
        .o_bin       (w_egk_bin),
        .o_last      (w_egk_last)
    );

    always_comb begin
        w_append = 1'b0;
        w_bin    = 1'b0;
        case (r_state)
            ST_PREFIX: begin
                w_append = 1'b1;
                w_bin    = w_pbin;
            end
            ST_SUF_UNARY, ST_SUF_FIXED: begin
                w_append = w_egk_valid;
                w_bin    = w_egk_bin;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_value <= '0;
            r_pcnt  <= '0;
            r_done  <= 1'b0;
            r_bins  <= '0;
            r_len   <= '0;
        end else begin
            // Older bins fall off the top once the string exceeds BIN_WIDTH; length keeps counting
            if (w_append) begin
                r_bins <= {r_bins[BIN_WIDTH-2:0], w_bin};
                r_len  <= r_len + 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_PREFIX;
                        r_value <= Cu_qp_delta_abs;
                        r_pcnt  <= '0;
                        r_bins  <= '0;
                        r_len   <= '0;
                    end
                end
                ST_PREFIX: begin
                    r_pcnt <= r_pcnt + 1'b1;
                    if (!w_pbin) begin
                        r_state <= ST_DONE;
                    end else if (w_egk_start) begin
                        r_state <= ST_SUF_UNARY;
                    end
                end
                ST_SUF_UNARY: begin
                    if (w_egk_last) begin
                        r_state <= ST_DONE;
                    end else if (!w_egk_bin) begin
                        r_state <= ST_SUF_FIXED;
                    end
                end
                ST_SUF_FIXED: begin
                    if (w_egk_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // First DONE cycle arms the pulse, second cycle carries it; start is ignored in both
                    if (!r_done) begin
                        r_done <= 1'b1;
                    end else begin
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign done       = r_done;
    assign bin_string = r_bins;
    assign bin_length = r_len;

endmodule

// File: tb/tb_qp_delta.sv
// Randomized bench for qp_delta against a plain-arithmetic bin-string model.
module tb_qp_delta;

    localparam int BW = 16;
    localparam int VW = 16;
    localparam int KO = 0;

    logic          clk;
    logic          rst;
    logic          start;
    logic [VW-1:0] value;
    logic          done;
    logic [BW-1:0] bin_string;
    logic [BW-1:0] bin_length;

    int n_total = 0;
    int n_bad   = 0;

    qp_delta #(
        .BIN_WIDTH   (BW),
        .VALUE_WIDTH (VW),
        .K           (KO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .Cu_qp_delta_abs (value),
        .done            (done),
        .bin_string      (bin_string),
        .bin_length      (bin_length)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Whole bin string as an integer (last bin in bit 0) plus its length
    function automatic void model(input longint v, output logic [63:0] acc, output int len);
        longint s;
        longint pw;
        int     k;
        acc = '0;
        len = 0;
        for (int i = 0; i < 5 && i < v; i++) begin
            acc = {acc[62:0], 1'b1};
            len++;
        end
        if (v < 5) begin
            acc = {acc[62:0], 1'b0};
            len++;
        end else begin
            s  = v - 5;
            k  = KO;
            pw = longint'(1) << k;
            while (s >= pw) begin
                acc = {acc[62:0], 1'b1};
                len++;
                s  = s - pw;
                k++;
                pw = pw * 2;
            end
            acc = {acc[62:0], 1'b0};
            len++;
            for (int b = k - 1; b >= 0; b--) begin
                acc = {acc[62:0], s[b]};
                len++;
            end
        end
    endfunction

    task automatic run(input logic [VW-1:0] v, input bit busy_start, input bit done_start);
        logic [63:0] eacc;
        int          elen;
        int          edges;
        bit          seen;
        model(longint'(v), eacc, elen);
        @(negedge clk);
        start = 1'b1;
        value = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        value = VW'($urandom);
        edges = 0;
        seen  = 0;
        while (!seen && edges < 200) begin
            @(posedge clk);
            edges++;
            #1;
            if (done) seen = 1;
            start = busy_start && (edges == 2);
            if (start) value = VW'($urandom);
        end
        check($sformatf("done_seen v=%0d", v), 64'(seen), 64'd1);
        check($sformatf("latency v=%0d", v), 64'(edges), 64'(elen + 1));
        check($sformatf("length v=%0d", v), 64'(bin_length), 64'(elen));
        check($sformatf("string v=%0d", v), 64'(bin_string), 64'(eacc[BW-1:0]));
        if (done_start) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check($sformatf("done_pulse_end v=%0d", v), 64'(done), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("hold_len v=%0d", v), 64'(bin_length), 64'(elen));
        check($sformatf("hold_str v=%0d", v), 64'(bin_string), 64'(eacc[BW-1:0]));
    endtask

    task automatic reset_mid(input logic [VW-1:0] v);
        int done_hits;
        @(negedge clk);
        start = 1'b1;
        value = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_str", 64'(bin_string), 64'd0);
        check("rst_mid_len", 64'(bin_length), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        done_hits = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) done_hits++;
        end
        check("rst_mid_no_done", 64'(done_hits), 64'd0);
        check("rst_mid_len_idle", 64'(bin_length), 64'd0);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        value = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", 64'(done), 64'd0);
        check("reset_str", 64'(bin_string), 64'd0);
        check("reset_len", 64'(bin_length), 64'd0);
        rst = 1'b1;

        run(16'd3, 0, 0);
        check("v3_const_str", 64'(bin_string), 64'h000E);
        run(16'd8, 0, 0);
        check("v8_const_str", 64'(bin_string), 64'h03F8);
        run(16'd1, 0, 0);
        run(16'd0, 0, 0);
        run(16'd5, 0, 0);
        check("v5_const_str", 64'(bin_string), 64'h003E);
        run(16'd4, 0, 0);
        check("v4_const_len", 64'(bin_length), 64'd5);
        run(16'd6, 1, 1);
        run(16'd1000, 1, 0);
        run(16'd65535, 0, 1);
        run(16'd0, 1, 1);

        reset_mid(16'd1000);
        run(16'd7, 0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [VW-1:0] rv;
            case ($urandom_range(0, 2))
                0:       rv = VW'($urandom_range(0, 12));
                1:       rv = VW'($urandom_range(0, 300));
                default: rv = VW'($urandom);
            endcase
            run(rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
